// File: rtl/win_scan_sched.sv
// Win-check scan scheduler: walks every five-cell-capable board line once per move
// and latches the first colour reported back. Optional early exit: WIN_SCAN_EARLY_EXIT_EN.
module win_scan_sched #(
  parameter int unsigned N     = 16,
  parameter int unsigned LAT   = 2,
  parameter int unsigned IDX_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             line_valid,
  output logic [1:0]       line_type,
  output logic [IDX_W-1:0] line_idx,
  input  logic [1:0]       line_result,
  output logic             done,
  output logic [1:0]       winner,
  output logic [6:0]       lines_issued
);

`ifdef WIN_SCAN_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] T_ROW  = 2'b00;
  localparam logic [1:0] T_ANTI = 2'b11;

  localparam logic [IDX_W-1:0] ROW_LAST  = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] DIAG_LAST = IDX_W'(2 * N - 10);

  logic [1:0]       state_q, state_d;
  logic [LAT-1:0]   trk_q, trk_d, trk_shift;
  logic             busy_d, valid_d, done_d;
  logic [1:0]       type_d, winner_d;
  logic [IDX_W-1:0] idx_d;
  logic [6:0]       lines_d;
  logic             result_mark, hit, type_last, last_line;

  // Tracker bit LAT-1 is set in exactly the cycle the issued line's result arrives.
  assign trk_shift   = (trk_q << 1) | LAT'(line_valid);
  assign result_mark = trk_q[LAT-1];
  assign hit         = result_mark && (line_result != 2'b00) && (winner == 2'b00);
  assign type_last   = line_type[1] ? (line_idx == DIAG_LAST) : (line_idx == ROW_LAST);
  assign last_line   = (line_type == T_ANTI) && (line_idx == DIAG_LAST);

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    type_d   = line_type;
    idx_d    = line_idx;
    winner_d = hit ? line_result : winner;
    lines_d  = lines_issued + 7'(line_valid);
    trk_d    = trk_shift;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ISSUE;
          valid_d  = 1'b1;
          type_d   = T_ROW;
          idx_d    = '0;
          winner_d = 2'b00;
          lines_d  = 7'd0;
        end
      end
      S_ISSUE: begin
        if (last_line || (EARLY_EXIT && hit)) begin
          state_d = S_DRAIN;
        end else begin
          valid_d = 1'b1;
          if (type_last) begin
            type_d = 2'(line_type + 2'd1);
            idx_d  = '0;
          end else begin
            idx_d  = line_idx + IDX_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (trk_shift == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      trk_q        <= '0;
      busy         <= 1'b0;
      line_valid   <= 1'b0;
      line_type    <= 2'b00;
      line_idx     <= '0;
      done         <= 1'b0;
      winner       <= 2'b00;
      lines_issued <= 7'd0;
    end else begin
      state_q      <= state_d;
      trk_q        <= trk_d;
      busy         <= busy_d;
      line_valid   <= valid_d;
      line_type    <= type_d;
      line_idx     <= idx_d;
      done         <= done_d;
      winner       <= winner_d;
      lines_issued <= lines_d;
    end
  end

endmodule

// File: tb/tb_win_scan_sched.sv
// Bench for win_scan_sched: emulates the check datapath from a per-line result table
// and compares every cycle of each scan against a scan-order model.
module tb_win_scan_sched;
  localparam int unsigned N     = 16;
  localparam int unsigned LAT   = 2;
  localparam int unsigned IDX_W = 5;
  localparam int          ND    = 2 * N - 9;
  localparam int          NL    = 2 * N + 2 * ND;

  logic             clk, reset, start, busy, line_valid, done;
  logic [1:0]       line_type, line_result, winner;
  logic [IDX_W-1:0] line_idx;
  logic [6:0]       lines_issued;

  win_scan_sched #(.N(N), .LAT(LAT), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .line_valid(line_valid), .line_type(line_type), .line_idx(line_idx),
    .line_result(line_result), .done(done), .winner(winner),
    .lines_issued(lines_issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0d want %0d", nm, cyc, act, exp);
    end
  endtask

  // Per-line results in scan order: rows, columns, diagonals, anti-diagonals
  logic [1:0] board [NL];

  function automatic int len_of(input int t);
    return (t < 2) ? N : ND;
  endfunction

  function automatic int base_of(input int t);
    int b = 0;
    for (int k = 0; k < t; k++) b += len_of(k);
    return b;
  endfunction

  task automatic line_of(input int k, output int t, output int i);
    t = 0;
    i = k;
    while (t < 3 && i >= len_of(t)) begin
      i -= len_of(t);
      t++;
    end
  endtask

  function automatic logic [1:0] lookup(input logic [1:0] t, input logic [IDX_W-1:0] i);
    if (int'(i) < len_of(int'(t))) return board[base_of(int'(t)) + int'(i)];
    return 2'b00;
  endfunction

  task automatic clear_board();
    for (int k = 0; k < NL; k++) board[k] = 2'b00;
  endtask

  // Datapath emulation: result of the line seen LAT cycles ago, junk otherwise
  logic       pv [LAT+1];
  logic [1:0] pr [LAT+1];
  logic [1:0] idle_val = 2'b11;

  always @(negedge clk) begin
    for (int i = LAT; i > 0; i--) begin
      pv[i] = pv[i-1];
      pr[i] = pr[i-1];
    end
    pv[0] = line_valid;
    pr[0] = line_valid ? lookup(line_type, line_idx) : 2'b00;
    line_result = pv[LAT] ? pr[LAT] : idle_val;
  end

  // Scan model state
  int L, hit_pos, abort_at, t0, chk_en, chk_last;
  int done_at, li_at_done, win_at_done;
  logic [1:0] hit_col;

  task automatic setup_model();
    hit_pos = -1;
    hit_col = 2'b00;
    for (int k = 0; k < NL; k++)
      if (hit_pos < 0 && board[k] != 2'b00) begin
        hit_pos = k;
        hit_col = board[k];
      end
    L = NL;
`ifdef WIN_SCAN_EARLY_EXIT_EN
    if (hit_pos >= 0 && hit_pos + 1 + int'(LAT) < NL) L = hit_pos + 1 + int'(LAT);
`endif
  endtask

  task automatic model(input int c, output int ev, output int eb, output int ed,
                       output int ew, output int eli, output int et, output int ei);
    et = 0;
    ei = 0;
    if (abort_at > 0 && c > abort_at) begin
      ev = 0; eb = 0; ed = 0; ew = 0; eli = 0;
    end else begin
      ev  = (c >= 1 && c <= L) ? 1 : 0;
      eb  = (c >= 1 && c <= L + int'(LAT)) ? 1 : 0;
      ed  = (c == L + int'(LAT) + 1) ? 1 : 0;
      ew  = (hit_pos >= 0 && c >= hit_pos + int'(LAT) + 2) ? int'(hit_col) : 0;
      eli = (c - 1 < L) ? c - 1 : L;
      if (ev != 0) line_of(c - 1, et, ei);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    int c, ev, eb, ed, ew, eli, et, ei;
    if (chk_en != 0) begin
      c = cyc - t0;
      if (c >= 1 && c <= chk_last) begin
        model(c, ev, eb, ed, ew, eli, et, ei);
        chk("line_valid", int'(line_valid), ev);
        chk("busy", int'(busy), eb);
        chk("done", int'(done), ed);
        chk("winner", int'(winner), ew);
        chk("lines_issued", int'(lines_issued), eli);
        if (ev != 0) begin
          chk("line_type", int'(line_type), et);
          chk("line_idx", int'(line_idx), ei);
        end
        if (done) begin
          done_at     = c;
          li_at_done  = int'(lines_issued);
          win_at_done = int'(winner);
        end
      end
    end
  end

  // Runs one scan from the current board; optional reset cycle and stray starts
  task automatic run_scan(input int abort_i, input int s1, input int s2);
    setup_model();
    abort_at = abort_i;
    chk_last = (abort_i > 0) ? abort_i + 3 : L + int'(LAT) + 3;
    done_at  = -1;
    @(negedge clk);
    start  = 1'b1;
    t0     = cyc;
    chk_en = 1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 2; c <= chk_last + 1; c++) begin
      @(negedge clk);
      start = (c == s1 || c == s2);
      reset = (c == abort_i);
    end
    start  = 1'b0;
    reset  = 1'b0;
    chk_en = 0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    line_result = 2'b00;
    chk_en = 0;
    t0 = 0;
    abort_at = 0;
    for (int i = 0; i <= LAT; i++) begin
      pv[i] = 1'b0;
      pr[i] = 2'b00;
    end
    clear_board();

    // Reset values, then a quiet idle period
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(line_valid), 0);
    chk("rst_type", int'(line_type), 0);
    chk("rst_idx", int'(line_idx), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_winner", int'(winner), 0);
    chk("rst_lines", int'(lines_issued), 0);
    reset = 1'b0;
    idle_val = 2'b00;
    repeat (20) begin
      @(negedge clk);
      chk("idle_valid", int'(line_valid), 0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(done), 0);
      chk("idle_winner", int'(winner), 0);
    end
    idle_val = 2'b11;

    // Empty board: full scan, no winner
    run_scan(0, -1, -1);
    chk("empty_done_at", done_at, 81);
    chk("empty_winner", win_at_done, 0);
    chk("empty_lines", li_at_done, 78);

    // Row 3 holds colour 1
    clear_board();
    board[3] = 2'b01;
    run_scan(0, -1, -1);
    chk("row3_winner", win_at_done, 1);
`ifdef WIN_SCAN_EARLY_EXIT_EN
    chk("row3_done_at", done_at, 9);
    chk("row3_lines", li_at_done, 6);
`else
    chk("row3_done_at", done_at, 81);
    chk("row3_lines", li_at_done, 78);
`endif

    // Column 15 colour 2 beats anti-diagonal 0 colour 1; stray starts in ISSUE and DONE
    clear_board();
    board[2*N-1]  = 2'b10;
    board[2*N+ND] = 2'b01;
`ifdef WIN_SCAN_EARLY_EXIT_EN
    run_scan(0, 20, 37);
    chk("two_done_at", done_at, 37);
    chk("two_lines", li_at_done, 34);
`else
    run_scan(0, 20, 81);
    chk("two_done_at", done_at, 81);
    chk("two_lines", li_at_done, 78);
`endif
    chk("two_winner", win_at_done, 2);

    // Reset at cycle 40 of a scan with column 4 colour 2
    clear_board();
    board[N+4] = 2'b10;
    run_scan(40, -1, -1);
    chk("abort_valid", int'(line_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_winner", int'(winner), 0);
    chk("abort_lines", int'(lines_issued), 0);

    // Fresh scan: only the last anti-diagonal reports 11, latched as-is
    clear_board();
    board[NL-1] = 2'b11;
    run_scan(0, -1, -1);
    chk("last_done_at", done_at, 81);
    chk("last_winner", win_at_done, 3);
    chk("last_lines", li_at_done, 78);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/win_scan_sched.md
Name: win_scan_sched

Overview:
- Sequences the five-in-a-row check datapath across the whole board after each move.
- Issues one board line (row, column, diagonal or anti-diagonal) per cycle to the board-read mux. The per-line check and summarize units sit behind that mux.
- Collects each 2-bit summarized line result a fixed number of cycles later and reports the first winner colour found.
- Sits between the game FSM (start/done) and the check datapath (line select in, summarized result out).

Parameters:
- N, 16, board side length in cells; each row/column yields 12 five-cell windows.
- LAT, 2, cycles from line_valid issue to line_result valid at the controller input (1..4).
- IDX_W, 5, width of line_idx; must hold 2N-10.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin a full board scan
- busy  out  1  scan in progress (ISSUE or DRAIN)
- line_valid  out  1  line_type/line_idx valid this cycle
- line_type  out  2  00 row, 01 column, 10 diagonal, 11 anti-diagonal
- line_idx  out  IDX_W  line index within type
- line_result  in  2  summarized result for the line issued LAT cycles earlier: 00 none, 01 colour 1, 10 colour 2
- done  out  1  one-cycle pulse: scan complete, winner valid
- winner  out  2  00 no winner, else colour of first hit; held until next start
- lines_issued  out  7  lines issued in the last/current scan

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE, busy=0, line_valid=0, line_type=0, line_idx=0, done=0, winner=00, lines_issued=0. The in-flight tracker is cleared.
- Scan order: rows 0..N-1, then columns 0..N-1, then diagonals 0..2N-10, then anti-diagonals 0..2N-10. Only diagonals of length >=5 are issued. For N=16 that is 16+16+23+23 = 78 lines.
- Diagonal d covers cells whose (col - row) = d-(N-5). Anti-diagonal d covers cells whose (row + col) = d+4.
- IDLE:
  - start=1 -> ISSUE; winner cleared to 00, lines_issued cleared to 0.
  - start is ignored outside IDLE, including in DONE.
- ISSUE:
  - line_valid=1 each cycle with the next line in scan order. The first line is issued in the cycle after start is sampled.
  - lines_issued increments per issued line.
  - After the last anti-diagonal is issued -> DRAIN.
- Result tracking:
  - A LAT-deep valid shift register marks which cycles carry a line_result.
  - line_result is sampled only in marked cycles; it is ignored otherwise.
- Winner capture:
  - The first marked nonzero line_result is latched into winner.
  - Later nonzero results are ignored. A value of 11 is latched as-is.
- DRAIN:
  - line_valid=0.
  - When the tracker is empty (the last marked result has been consumed) -> DONE.
- DONE: done=1 for exactly one cycle, then -> IDLE. busy=0 in DONE.
- Latency (no early exit): with start sampled at cycle 0, lines issue in cycles 1..78. The last result arrives at 78+LAT and done pulses at 79+LAT (81 for LAT=2).
- Reset mid-scan: immediate return to IDLE with reset values. Results already in the datapath pipeline are ignored because the tracker is cleared.
- Simultaneous start and reset: reset wins.

Optional Feature:
- Macro: WIN_SCAN_EARLY_EXIT_EN.
- Defined:
  - The first marked nonzero result in ISSUE forces DRAIN from the next cycle; no further lines are issued.
  - Results still in flight are consumed but cannot change winner.
  - done pulses the cycle after the tracker empties. lines_issued reflects only the lines actually issued.
- Undefined:
  - The full 78-line scan always runs; the winner is still the first hit.
  - done timing is independent of the result values.

Test Plan:
- Reset then idle: all line_result=00, no start for 20 cycles -> line_valid, busy, done stay 0; winner=00.
- Empty board: start at cycle 0, LAT=2, all results 00 -> 78 consecutive line_valid cycles (1..78) in the specified order, with line_idx 0..15, 0..15, 0..22, 0..22. done at cycle 81, winner=00, lines_issued=78.
- Row 3 hit, colour 01, early exit defined: result 01 in cycle 6 -> line_valid low from cycle 7, done at cycle 9, winner=01, lines_issued=6.
- Same stimulus, early exit undefined -> full scan, done at cycle 81, winner=01, lines_issued=78.
- Two hits, column 15 = 10 and anti-diagonal 0 = 01, no early exit -> winner=10 (column 15 is the earlier line in scan order).
- Reset asserted at cycle 40 mid-scan -> next cycle line_valid=0, busy=0, winner=00. A start at cycle 45 begins a fresh scan from row 0 and completes normally.
- start pulsed during ISSUE or DONE -> ignored; no restart, line order unchanged.
